line_buffer_sdp: RTL

Parametrised multi-line video buffer built on N single-clock read-first simple-dual-port RAMs, one per stored line. It generalises the fixed 8x2048 SDP RAM into a line-delay engine for the stitching datapath. Each accepted pixel is emitted together with the co-located pixels of the previous NUM_LINES lines, feeding vertical blend and filter stages. Line-length overrun is detected and handled, and frame-start resynchronisation is built in.

---
 rtl/line_buffer_sdp_pkg.sv | 26 ++
 rtl/line_buffer_sdp_if.sv | 47 ++++
 rtl/line_buffer_sdp_line_ram.sv | 43 ++++
 rtl/line_buffer_sdp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_sdp_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_pkg
//   Shared types and helpers for the line_buffer_sdp line-delay engine.
//   - lb_state_e : control FSM state (IDLE / ACTIVE / DISCARD)
//   - clog2_sat  : width of a counter that must hold 0..n inclusive (min 1)
//   - TAP_W      : tap bus width for the default configuration
// -----------------------------------------------------------------------------
package line_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2
  } lb_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_LINES  = 2;
  localparam int TAP_W          = DEF_NUM_LINES * DEF_DATA_WIDTH;

  // Bits needed to count 0..n inclusive; never narrower than one bit.
  function automatic int clog2_sat(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/line_buffer_sdp_if.sv
// -----------------------------------------------------------------------------
// line_buffer_sdp_if
//   Pixel-in / taps-out bundle of line_buffer_sdp.
//   slave  : the line buffer (consumes pixels, produces delayed pixel + taps)
//   master : the pixel source / downstream observer
//   Inputs : frame_start, in_valid, in_data, in_eol
//   Outputs: out_valid, out_data, out_taps, out_taps_valid, line_len_err,
//            lines_filled, state_dbg (FSM state for observation)
//
// Stream semantics: there is no ready. A pixel moves on every cycle in which
// in_valid is high; the buffer never stalls the source. in_eol and in_data are
// only meaningful when in_valid is high. out_valid marks each cycle that
// carries an accepted pixel; out_data/out_taps hold their value otherwise.
// -----------------------------------------------------------------------------
interface line_buffer_sdp_if
  import line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LINES  = DEF_NUM_LINES
);
  localparam int LF_W = clog2_sat(NUM_LINES);

  logic                             frame_start;
  logic                             in_valid;
  logic [DATA_WIDTH-1:0]            in_data;
  logic                             in_eol;
  logic                             out_valid;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [NUM_LINES*DATA_WIDTH-1:0]  out_taps;
  logic                             out_taps_valid;
  logic                             line_len_err;
  logic [LF_W-1:0]                  lines_filled;
  lb_state_e                        state_dbg;

  modport master (
    output frame_start, in_valid, in_data, in_eol,
    input  out_valid, out_data, out_taps, out_taps_valid, line_len_err,
           lines_filled, state_dbg
  );

  modport slave (
    input  frame_start, in_valid, in_data, in_eol,
    output out_valid, out_data, out_taps, out_taps_valid, line_len_err,
           lines_filled, state_dbg
  );

endinterface

// File: rtl/line_buffer_sdp_line_ram.sv
// -----------------------------------------------------------------------------
// line_ram
//   Single-clock simple-dual-port RAM, read-first, registered read.
//   Ports: clk, rst_n (clears only the read register, not the array),
//          wr_en/wr_addr/wr_data (write port), rd_en/rd_addr (read port),
//          rd_data (registered read data, holds when rd_en is low).
//   A read and write to the same address in one cycle returns the old word.
// -----------------------------------------------------------------------------
module line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // mem is sampled before the same-edge write lands: read-first behaviour.
  always_comb begin
    rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer_sdp.sv
// -----------------------------------------------------------------------------
// line_buffer_sdp
//   Multi-line video delay: each accepted pixel is emitted with the pixels of
//   the same column from the previous NUM_LINES lines (one line_ram per line,
//   written round-robin by wr_sel).
//   Ports: clk, rst_n (async, active-low), bus (line_buffer_sdp_if.slave).
//   Build option: LB_OUTPUT_REG_EN adds one register stage on out_valid,
//   out_data, out_taps, out_taps_valid and line_len_err (latency 2 instead of 1).
// -----------------------------------------------------------------------------
module line_buffer_sdp
  import line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_LINES    = 2,
  parameter int ADDR_WIDTH   = 11,
  parameter int MAX_LINE_LEN = 1920
) (
  input  logic             clk,
  input  logic             rst_n,
  line_buffer_sdp_if.slave bus
);

  localparam int SEL_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int LF_W   = clog2_sat(NUM_LINES);
  localparam int TAPS_W = NUM_LINES * DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(MAX_LINE_LEN - 1);
  localparam logic [SEL_W-1:0]      LAST_SEL = SEL_W'(NUM_LINES - 1);
  localparam logic [LF_W-1:0]       FULL_LF  = LF_W'(NUM_LINES);

  lb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d, col_eff;
  logic [SEL_W-1:0]      wr_sel_q, wr_sel_d, sel_eff;
  logic [SEL_W-1:0]      rd_sel_q, rd_sel_d;
  logic [LF_W-1:0]       lf_q, lf_d, lf_eff;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  taps_valid_q, taps_valid_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  end_line;
  logic [DATA_WIDTH-1:0] rd_data [NUM_LINES];
  logic [TAPS_W-1:0]     taps_c;

  always_comb begin
    // frame_start overrides all line state for this cycle, so a coincident
    // pixel is treated as column 0 of line 0.
    col_eff  = bus.frame_start ? '0 : col_q;
    sel_eff  = bus.frame_start ? '0 : wr_sel_q;
    lf_eff   = bus.frame_start ? '0 : lf_q;
    accept   = bus.in_valid && (bus.frame_start || (state_q == ACTIVE));
    // In DISCARD the eol pixel still closes the line, but is not written.
    end_line = bus.in_valid && bus.in_eol && (accept || (state_q == DISCARD));

    state_d  = bus.frame_start ? ACTIVE : state_q;
    col_d    = col_eff;
    wr_sel_d = sel_eff;
    lf_d     = lf_eff;
    err_d    = 1'b0;

    if (end_line) begin
      col_d    = '0;
      wr_sel_d = (sel_eff == LAST_SEL) ? '0 : sel_eff + SEL_W'(1);
      lf_d     = (lf_eff == FULL_LF) ? lf_eff : lf_eff + LF_W'(1);
      state_d  = ACTIVE;
    end else if (accept) begin
      if (col_eff == LAST_COL) begin
        // Overrun: keep col parked on the last column and drop the rest.
        err_d   = 1'b1;
        state_d = DISCARD;
      end else begin
        col_d = col_eff + ADDR_WIDTH'(1);
      end
    end

    out_valid_d  = accept;
    out_data_d   = accept ? bus.in_data : out_data_q;
    taps_valid_d = accept && (lf_eff == FULL_LF);
    rd_sel_d     = accept ? sel_eff : rd_sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      wr_sel_q     <= '0;
      rd_sel_q     <= '0;
      lf_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      taps_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      lf_q         <= lf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      taps_valid_q <= taps_valid_d;
      err_q        <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept && (sel_eff == SEL_W'(i))),
      .wr_addr (col_eff),
      .wr_data (bus.in_data),
      .rd_en   (accept),
      .rd_addr (col_eff),
      .rd_data (rd_data[i])
    );
  end

  // Tap k comes from RAM j where j == (rd_sel - 1 - k) mod N, i.e.
  // rd_sel == (j + 1 + k) mod N; the right-hand side is a constant per (j,k).
  always_comb begin
    taps_c = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      for (int j = 0; j < NUM_LINES; j++) begin
        if (rd_sel_q == SEL_W'((j + 1 + k) % NUM_LINES))
          taps_c[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[j];
      end
    end
  end

`ifdef LB_OUTPUT_REG_EN
  logic                  p2_valid_q, p2_valid_d;
  logic [DATA_WIDTH-1:0] p2_data_q, p2_data_d;
  logic [TAPS_W-1:0]     p2_taps_q, p2_taps_d;
  logic                  p2_tv_q, p2_tv_d;
  logic                  p2_err_q, p2_err_d;

  always_comb begin
    p2_valid_d = out_valid_q;
    p2_data_d  = out_data_q;
    p2_taps_d  = taps_c;
    p2_tv_d    = taps_valid_q;
    p2_err_d   = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_valid_q <= 1'b0;
      p2_data_q  <= '0;
      p2_taps_q  <= '0;
      p2_tv_q    <= 1'b0;
      p2_err_q   <= 1'b0;
    end else begin
      p2_valid_q <= p2_valid_d;
      p2_data_q  <= p2_data_d;
      p2_taps_q  <= p2_taps_d;
      p2_tv_q    <= p2_tv_d;
      p2_err_q   <= p2_err_d;
    end
  end

  assign bus.out_valid      = p2_valid_q;
  assign bus.out_data       = p2_data_q;
  assign bus.out_taps       = p2_taps_q;
  assign bus.out_taps_valid = p2_tv_q;
  assign bus.line_len_err   = p2_err_q;
`else
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_taps       = taps_c;
  assign bus.out_taps_valid = taps_valid_q;
  assign bus.line_len_err   = err_q;
`endif

  assign bus.lines_filled = lf_q;
  assign bus.state_dbg    = state_q;

endmodule
